switch_port_buf: RTL and testbench
==================================

SWITCH_PORT_BUF -- requirements
Module: switch_port_buf

Interface
REQ-001 Parameter NUM_PORTS, default 4, sets the width of the source and target one-hot/multicast masks.
REQ-002 Parameter DATA_W, default 8, sets the payload width.
REQ-003 Parameter DEPTH, default 4, sets the buffered packet count; power of two, >=2.
REQ-004 Parameter LATENCY, default 5, sets the minimum cycles from accept to eligible output; >=1.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 valid_in  in  1  upstream packet present.
REQ-008 ready_in  out  1  port can accept; equals !full.
REQ-009 source_in  in  NUM_PORTS  source mask.
REQ-010 target_in  in  NUM_PORTS  destination mask; zero means null packet.
REQ-011 data_in  in  DATA_W  payload.
REQ-012 flush  in  1  synchronous clear of all buffered packets.
REQ-013 valid_out  out  1  head packet eligible.
REQ-014 ready_out  in  1  downstream accepts head.
REQ-015 source_out, target_out, data_out  out  NUM_PORTS/NUM_PORTS/DATA_W  head packet fields.
REQ-016 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-017 drop_cnt  out  8  saturating count of null packets.

Function
REQ-018 Accept = valid_in && ready_in && target_in!=0 at a rising edge; the packet is written to the tail with its age set to 0.
REQ-019 Null packets (valid_in && ready_in && target_in==0) shall not be stored, and drop_cnt shall increment, saturating at 255.
REQ-020 ready_in shall depend only on registered occupancy, with no combinational path from ready_out.
REQ-021 Each stored entry's age shall increment every cycle and saturate at LATENCY.
REQ-022 valid_out shall be high exactly when the FIFO is non-empty and head age==LATENCY; a packet accepted at edge k appears no earlier than after edge k+LATENCY.
REQ-023 Pop = valid_out && ready_out; head fields shall be held stable while valid_out && !ready_out.
REQ-024 Output fields shall be the head fields, passed unmodified; the target mask is forwarded exactly.
REQ-025 Packets shall leave in strict acceptance order; a younger eligible entry never overtakes the head.
REQ-026 Simultaneous push and pop shall leave count unchanged; both operations take effect.
REQ-027 When full, ready_in shall be 0, and an offered packet shall be neither stored nor counted as dropped.
REQ-028 Read and write pointers shall wrap modulo DEPTH, and count shall stay within 0..DEPTH.
REQ-029 flush shall set count to 0 and clear pointers, and valid_out shall be 0 the next cycle; flush overrides push and pop in the same cycle; drop_cnt is not cleared.

Reset
REQ-030 On reset, pointers, count, all ages and drop_cnt shall be 0, valid_out shall be 0, and ready_in shall be 1 after reset deassertion.
REQ-031 Reset asserted mid-transfer shall discard all buffered packets immediately, with no partial output.
REQ-032 Payload storage needs no reset, but output fields shall read 0 while the FIFO is empty after reset.

Structure
REQ-033 Shared package switch_pkg shall hold the default constants (NUM_PORTS_DEF=4, DATA_W_DEF=8, DEPTH_DEF=4, LATENCY_DEF=5) and the null-target constant.
REQ-034 One sub-module, switch_fifo, shall implement the storage, pointers and count, parametrised by width and DEPTH; the age counters and handshake logic live in switch_port_buf.

Verification
REQ-035 Single packet: src=0001, tgt=0110, data=A5 accepted at edge 0 -> valid_out first high after edge 5 with 0001/0110/A5; ready_out=1 -> pop, count returns to 0.
REQ-036 Back-to-back: 4 packets on consecutive edges with ready_out=1 -> 4 outputs on consecutive cycles, in order; the 5th offered while full sees ready_in=0 and is not lost after retry.
REQ-037 Backpressure: ready_out=0 for 10 cycles after eligibility -> valid_out and fields stay stable; the release pops exactly one packet per cycle.
REQ-038 Null packet: target_in=0000 with valid_in -> count unchanged and drop_cnt +1; 300 nulls -> drop_cnt=255.
REQ-039 Full with push+pop in the same cycle -> count stays DEPTH and order is preserved; flush with 3 entries -> count=0, valid_out=0 next cycle.
REQ-040 Reset asserted with 2 entries mid-latency -> valid_out=0 and count=0 immediately; the first post-reset packet observes the full LATENCY.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared constants for the switch port buffer.
//   NUM_PORTS_DEF : default width of source/target masks
//   DATA_W_DEF    : default payload width
//   DEPTH_DEF     : default buffered packet count (power of two)
//   LATENCY_DEF   : default minimum accept-to-output latency in cycles
//   NULL_TARGET   : target mask value that marks a packet as null
package switch_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int DEPTH_DEF     = 4;
  localparam int LATENCY_DEF   = 5;
  localparam int NULL_TARGET   = 0;

endpackage

// File: rtl/switch_fifo.sv
// Packet storage ring for the switch port buffer.
//   clk, rst_n : clock and asynchronous active-low reset (control only)
//   flush_i    : synchronous clear of pointers and count, wins over push/pop
//   push_i     : write wr_data_i at the tail (caller guarantees !full_o)
//   pop_i      : retire the head entry (caller guarantees !empty_o)
//   rd_data_o  : head entry contents
//   wr_ptr_o, rd_ptr_o : physical slot indices of tail and head
//   count_o, full_o, empty_o : occupancy status
module switch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer increments wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; consumers gate it with empty_o.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/switch_port_buf.sv
// Switch output-port buffer: in-order packet FIFO with a minimum residency
// latency, null-packet dropping and a saturating drop counter.
//   valid_in/ready_in     : upstream handshake (ready_in = !full)
//   source_in/target_in/data_in : packet fields; target_in == 0 is a null
//   flush                 : synchronous clear of all buffered packets
//   valid_out/ready_out   : downstream handshake for the head packet
//   source_out/target_out/data_out : head packet fields (0 while empty)
//   count                 : current occupancy
//   drop_cnt              : saturating count of dropped null packets
module switch_port_buf
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int LATENCY   = LATENCY_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [NUM_PORTS-1:0]       source_in,
  input  logic [NUM_PORTS-1:0]       target_in,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       flush,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [NUM_PORTS-1:0]       source_out,
  output logic [NUM_PORTS-1:0]       target_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int AGE_W = $clog2(LATENCY+1);
  localparam int PKT_W = 2*NUM_PORTS + DATA_W;

  logic [PKT_W-1:0] rd_pkt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             full, empty;
  logic             is_null, offer, push, pop, null_hit;

  logic [AGE_W-1:0] age_q [DEPTH];
  logic [AGE_W-1:0] age_d [DEPTH];
  logic [7:0]       drop_q, drop_d;

  // ready_in comes straight from registered occupancy, never from ready_out.
  assign ready_in  = !full;
  assign is_null   = (target_in == NUM_PORTS'(NULL_TARGET));
  assign offer     = valid_in && ready_in;
  assign push      = offer && !is_null && !flush;
  assign null_hit  = offer && is_null;
  assign valid_out = !empty && (age_q[rd_ptr] == AGE_W'(LATENCY));
  assign pop       = valid_out && ready_out && !flush;

  switch_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i ({source_in, target_in, data_in}),
    .rd_data_o (rd_pkt),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .count_o   (fifo_count),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Ages are kept per physical slot; a slot restarts at 0 when written and
  // otherwise climbs to LATENCY and stays there.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (push && (wr_ptr == PTR_W'(i)))
        age_d[i] = '0;
      else if (age_q[i] != AGE_W'(LATENCY))
        age_d[i] = age_q[i] + 1'b1;
    end
    drop_d = drop_q;
    if (null_hit && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q  <= '{default: '0};
      drop_q <= '0;
    end else begin
      age_q  <= age_d;
      drop_q <= drop_d;
    end
  end

  // Stale storage is hidden while empty so the outputs read 0.
  assign {source_out, target_out, data_out} = empty ? '0 : rd_pkt;
  assign count    = fifo_count;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_switch_port_buf.sv
module tb_switch_port_buf;

  localparam int NP  = 4;
  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic          ready_in;
  logic [NP-1:0] source_in, target_in;
  logic [DW-1:0] data_in;
  logic          flush;
  logic          valid_out;
  logic          ready_out;
  logic [NP-1:0] source_out, target_out;
  logic [DW-1:0] data_out;
  logic [2:0]    count;
  logic [7:0]    drop_cnt;

  typedef struct {
    logic [15:0] pkt;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   mcount = 0;
  int   mdrop  = 0;

  switch_port_buf #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .DEPTH     (DEP),
    .LATENCY   (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .source_in  (source_in),
    .target_in  (target_in),
    .data_in    (data_in),
    .flush      (flush),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .source_out (source_out),
    .target_out (target_out),
    .data_out   (data_out),
    .count      (count),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; drop valid_in once a real packet has been taken.
  task automatic step();
    logic hs;
    hs = valid_in && ready_in && (target_in != '0);
    @(posedge clk);
    #1;
    if (hs) valid_in = 1'b0;
  endtask

  task automatic offer(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    valid_in  = 1'b1;
    source_in = s;
    target_in = t;
    data_in   = d;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_out && n < 30) begin step(); n++; end
    chk(tag, (n < 30), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((count != 0 || sb.size() != 0 || valid_in) && n < 60) begin step(); n++; end
    chk(tag, (n < 60), 1);
  endtask

  // Scoreboard and occupancy/drop model, sampled mid-cycle.
  always @(negedge clk) begin
    logic macc, mnull;
    if (!rst_n) begin
      sb.delete();
      mcount = 0;
      mdrop  = 0;
      chk("mon_rst_valid", valid_out, 0);
      chk("mon_rst_count", count, 0);
    end else begin
      chk("mon_count", count, mcount);
      chk("mon_drop", drop_cnt, mdrop);
      chk("mon_ready_in", ready_in, (mcount < DEP));
      if (mcount == 0) begin
        chk("mon_empty_valid", valid_out, 0);
        chk("mon_empty_fields", {source_out, target_out, data_out}, 0);
      end
      if (valid_out) begin
        if (sb.size() == 0) chk("mon_unexpected_out", 1, 0);
        else begin
          chk("mon_head_fields", {source_out, target_out, data_out}, sb[0].pkt);
          chk("mon_min_latency", (cyc >= sb[0].acc + LAT), 1);
        end
      end
      macc  = valid_in && (mcount < DEP) && (target_in != '0);
      mnull = valid_in && (mcount < DEP) && (target_in == '0);
      if (mnull && mdrop < 255) mdrop++;
      if (flush) begin
        sb.delete();
        mcount = 0;
      end else begin
        if (valid_out && ready_out && sb.size() > 0) begin
          void'(sb.pop_front());
          mcount--;
        end
        if (macc) begin
          sb.push_back('{pkt: {source_in, target_in, data_in}, acc: cyc + 1});
          mcount++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    rst_n = 1'b0; valid_in = 1'b0; source_in = '0; target_in = '0; data_in = '0;
    flush = 1'b0; ready_out = 1'b0;
    repeat (3) step();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_count", count, 0);
    chk("rst_ready_in", ready_in, 1);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_fields", {source_out, target_out, data_out}, 0);
    rst_n = 1'b1;
    step();

    // Single packet, exact latency.
    ready_out = 1'b1;
    offer(4'b0001, 4'b0110, 8'hA5);
    step();
    chk("single_count", count, 1);
    repeat (4) begin step(); chk("single_early", valid_out, 0); end
    step();
    chk("single_valid", valid_out, 1);
    chk("single_fields", {source_out, target_out, data_out}, 16'h16A5);
    step();
    chk("single_popped_count", count, 0);
    chk("single_popped_valid", valid_out, 0);

    // Back-to-back fill, fifth offered while full.
    for (int i = 0; i < 4; i++) begin
      offer(4'(1 << i), 4'(i + 1), 8'(8'h10 + i));
      step();
    end
    chk("b2b_full_count", count, 4);
    offer(4'b1000, 4'b1111, 8'h55);
    chk("b2b_full_ready_in", ready_in, 0);
    wait_valid("b2b_wait_valid");
    for (int j = 0; j < 4; j++) begin
      chk("b2b_consecutive", valid_out, 1);
      step();
    end
    wait_idle("b2b_drain");

    // Backpressure for 10 cycles after eligibility.
    ready_out = 1'b0;
    offer(4'b0010, 4'b0001, 8'hC3); step();
    offer(4'b0100, 4'b1000, 8'h3C); step();
    wait_valid("bp_wait_valid");
    held = {source_out, target_out, data_out};
    chk("bp_head", held, 16'h21C3);
    repeat (10) begin
      step();
      chk("bp_hold_valid", valid_out, 1);
      chk("bp_hold_fields", {source_out, target_out, data_out}, held);
    end
    ready_out = 1'b1;
    step();
    chk("bp_release_one", count, 1);
    chk("bp_second_valid", valid_out, 1);
    step();
    chk("bp_release_two", count, 0);

    // Null packets and saturation.
    offer(4'b0001, 4'b0000, 8'h33);
    step();
    valid_in = 1'b0;
    chk("null_count", count, 0);
    chk("null_drop_one", drop_cnt, 1);
    valid_in = 1'b1;
    repeat (299) step();
    valid_in = 1'b0;
    chk("null_drop_sat", drop_cnt, 255);
    chk("null_count_after", count, 0);

    // Full, then pop-only followed by push+pop.
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(4'(8 >> i), 4'(4'b1001 ^ i), 8'(8'h80 + i));
      step();
    end
    repeat (6) step();
    chk("pp_full", count, 4);
    offer(4'b0011, 4'b1100, 8'hEE);
    ready_out = 1'b1;
    step();
    chk("pp_pop_only", count, 3);
    step();
    chk("pp_push_pop", count, 3);
    wait_idle("pp_drain");

    // Flush with three entries.
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(4'b0001, 4'(i + 2), 8'(8'h40 + i));
      step();
    end
    chk("flush_pre_count", count, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", valid_out, 0);
    chk("flush_ready_in", ready_in, 1);
    chk("flush_keeps_drop", drop_cnt, 255);
    step();
    chk("flush_valid_later", valid_out, 0);

    // Reset with two entries mid-latency.
    ready_out = 1'b1;
    offer(4'b0100, 4'b0010, 8'h11); step();
    offer(4'b1000, 4'b0100, 8'h22); step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_count", count, 0);
    chk("midrst_drop", drop_cnt, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    offer(4'b0010, 4'b1010, 8'h77);
    step();
    repeat (4) begin step(); chk("postrst_early", valid_out, 0); end
    step();
    chk("postrst_valid", valid_out, 1);
    chk("postrst_fields", {source_out, target_out, data_out}, 16'h2A77);
    step();
    chk("postrst_count", count, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
